// File: rtl/spike_window_counter_pkg.sv
// Shared definitions for the spike window counter: FSM encoding, output width
// and a constant-evaluable clog2 helper used to size pointers and counters.
package spike_window_counter_pkg;

    localparam int OUT_W = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spike_popcount.sv
// Combinational population count of the spike lines active in one clock cycle.
module spike_popcount
    import spike_window_counter_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int PC_W   = clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0] spikes,
    output logic [PC_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count = count + PC_W'(spikes[i]);
        end
    end

endmodule

// File: rtl/spike_window_counter.sv
// Sliding-window spike counter: per-tick spike totals go into a WIN-entry ring and a
// running sum of the ring is published one cycle after every accepted tick.
module spike_window_counter
    import spike_window_counter_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int WIN    = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_tick,
    input  logic [NUM_CH-1:0] i_spikes,
    input  logic              i_clear,
    output logic [OUT_W-1:0]  o_spike_cnt,
    output logic              o_cnt_valid,
    output logic              o_window_full,
    output logic              o_sat,
    output logic              o_tick_drop,
    output state_t            o_state
);

    localparam int PTR_W = clog2(WIN);
    localparam int PC_W  = clog2(NUM_CH + 1);
    localparam int SUM_W = CNT_W + PTR_W;
    localparam int ADD_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(WIN - 1);
    localparam logic [ADD_W-1:0] ACC_MAX = ADD_W'({CNT_W{1'b1}});

    state_t           state;
    logic [PTR_W-1:0] init_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] acc;
    logic [SUM_W-1:0] sum;
    logic [PC_W-1:0]  pc;
    logic [ADD_W-1:0] acc_sum;
    logic             clamp;
    logic [CNT_W-1:0] slot;
    logic [CNT_W-1:0] old_entry;
    logic [SUM_W-1:0] sum_next;
    logic             tick_take;
    logic [CNT_W-1:0] ring [WIN];

    spike_popcount #(.NUM_CH(NUM_CH)) u_popcount (
        .spikes (i_spikes),
        .count  (pc)
    );

    // Spikes coincident with a tick are folded into the slot that tick closes.
    // The subtraction may wrap mid-expression but the final sum is always in range.
    always_comb begin
        acc_sum   = ADD_W'(acc) + ADD_W'(pc);
        clamp     = acc_sum > ACC_MAX;
        slot      = clamp ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
        old_entry = ring[wr_ptr];
        sum_next  = sum + SUM_W'(slot) - SUM_W'(old_entry);
        tick_take = (state != ST_INIT) && i_tick && !i_clear;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                ring[init_ptr] <= '0;
            end else if (tick_take) begin
                ring[wr_ptr] <= slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT;
            init_ptr      <= '0;
            wr_ptr        <= '0;
            acc           <= '0;
            sum           <= '0;
            o_cnt_valid   <= 1'b0;
            o_window_full <= 1'b0;
            o_sat         <= 1'b0;
            o_tick_drop   <= 1'b0;
        end else begin
            o_cnt_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (i_clear) begin
                        init_ptr <= '0;
                    end else begin
                        if (i_tick) o_tick_drop <= 1'b1;
                        if (init_ptr == LAST) begin
                            init_ptr <= '0;
                            state    <= ST_FILL;
                        end else begin
                            init_ptr <= init_ptr + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    if (i_clear) begin
                        state         <= ST_INIT;
                        init_ptr      <= '0;
                        wr_ptr        <= '0;
                        acc           <= '0;
                        sum           <= '0;
                        o_window_full <= 1'b0;
                    end else begin
                        if (clamp) o_sat <= 1'b1;
                        if (i_tick) begin
                            sum         <= sum_next;
                            acc         <= '0;
                            o_cnt_valid <= 1'b1;
                            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
                            // wr_ptr wraps exactly when the WIN-th slot since INIT closes
                            if (state == ST_FILL && wr_ptr == LAST) begin
                                state         <= ST_RUN;
                                o_window_full <= 1'b1;
                            end
                        end else begin
                            acc <= slot;
                        end
                    end
                end
            endcase
        end
    end

    assign o_spike_cnt = OUT_W'(sum);
    assign o_state     = state;

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed bench for spike_window_counter: a behavioural window model pushes expected
// sums on every accepted tick and each cycle's outputs are checked against it.
module tb_spike_window_counter;
    import spike_window_counter_pkg::*;

    localparam int NUM_CH = 8;
    localparam int WIN    = 16;
    localparam int CNT_W  = 16;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              clear = 1'b0;
    logic [NUM_CH-1:0] spikes = '0;
    logic              tick4 = 1'b0;
    logic [NUM_CH-1:0] spikes4 = '0;

    logic [31:0] o_spike_cnt, o4_spike_cnt;
    logic        o_cnt_valid, o_window_full, o_sat, o_tick_drop;
    logic        o4_cnt_valid, o4_window_full, o4_sat, o4_tick_drop;
    state_t      o_state, o4_state;

    spike_window_counter #(.NUM_CH(NUM_CH), .WIN(WIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .i_tick(tick), .i_spikes(spikes), .i_clear(clear),
        .o_spike_cnt(o_spike_cnt), .o_cnt_valid(o_cnt_valid), .o_window_full(o_window_full),
        .o_sat(o_sat), .o_tick_drop(o_tick_drop), .o_state(o_state)
    );

    spike_window_counter #(.NUM_CH(NUM_CH), .WIN(WIN), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .i_tick(tick4), .i_spikes(spikes4), .i_clear(1'b0),
        .o_spike_cnt(o4_spike_cnt), .o_cnt_valid(o4_cnt_valid), .o_window_full(o4_window_full),
        .o_sat(o4_sat), .o_tick_drop(o4_tick_drop), .o_state(o4_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    int          m_state;
    int          m_init, m_wr, m_acc, m_ticks;
    int          m_ring[WIN];
    logic [31:0] m_cnt;
    logic        m_full, m_sat, m_drop, m_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0;
        m_init  = 0;
        m_wr    = 0;
        m_acc   = 0;
        m_ticks = 0;
        m_cnt   = '0;
        m_full  = 1'b0;
        foreach (m_ring[k]) m_ring[k] = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_sat   = 1'b0;
        m_drop  = 1'b0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        chk("cnt_valid", 32'(o_cnt_valid), 32'(m_valid));
        if (m_valid) begin
            m_cnt = exp_q.pop_front();
            chk("spike_cnt_update", o_spike_cnt, m_cnt);
        end else begin
            chk("spike_cnt_hold", o_spike_cnt, m_cnt);
        end
        chk("window_full", 32'(o_window_full), 32'(m_full));
        chk("sat", 32'(o_sat), 32'(m_sat));
        chk("tick_drop", 32'(o_tick_drop), 32'(m_drop));
    endtask

    // One clock of stimulus: model the cycle, let the edge pass, then compare.
    task automatic step(input logic [NUM_CH-1:0] sp, input logic tk, input logic cl);
        int tot;
        int total;
        spikes  = sp;
        tick    = tk;
        clear   = cl;
        m_valid = 1'b0;
        if (m_state == 0) begin
            if (cl) m_init = 0;
            else begin
                if (tk) m_drop = 1'b1;
                if (m_init == WIN - 1) begin
                    m_init  = 0;
                    m_state = 1;
                end else m_init++;
            end
        end else if (cl) begin
            model_clear();
        end else begin
            tot = m_acc + $countones(sp);
            if (tot > MAXV) begin
                tot   = MAXV;
                m_sat = 1'b1;
            end
            if (tk) begin
                m_ring[m_wr] = tot;
                m_wr         = (m_wr + 1) % WIN;
                m_acc        = 0;
                m_ticks++;
                total = 0;
                foreach (m_ring[k]) total += m_ring[k];
                exp_q.push_back(32'(total));
                m_valid = 1'b1;
                if (m_ticks == WIN) begin
                    m_full  = 1'b1;
                    m_state = 2;
                end
            end else m_acc = tot;
        end
        @(posedge clk);
        #1;
        spikes = '0;
        tick   = 1'b0;
        clear  = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        chk("reset_state", 32'(o_state), 32'(ST_INIT));
        chk("dut4_reset_cnt", o4_spike_cnt, 32'd0);
        chk("dut4_reset_sat", 32'(o4_sat), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Reset, then the INIT sweep with window_full low throughout
        do_reset();
        for (int i = 0; i < WIN; i++) step('0, 1'b0, 1'b0);
        chk("fill_after_init", 32'(o_state), 32'(ST_FILL));
        step('0, 1'b1, 1'b0);
        chk("first_tick_valid", 32'(o_cnt_valid), 32'd1);
        chk("first_tick_cnt", o_spike_cnt, 32'd0);
        step('0, 1'b0, 1'b0);
        chk("valid_single_pulse", 32'(o_cnt_valid), 32'd0);

        // Clear from FILL, then 3 spikes per tick on line 0 for 20 ticks
        step('0, 1'b0, 1'b1);
        chk("clear_to_init", 32'(o_state), 32'(ST_INIT));
        for (int i = 0; i < WIN; i++) step('0, 1'b0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            step(8'h01, 1'b0, 1'b0);
            step(8'h01, 1'b0, 1'b0);
            step(8'h01, 1'b1, 1'b0);
            chk("ramp_cnt", o_spike_cnt, (t < 15) ? 32'(3 * (t + 1)) : 32'd48);
            chk("ramp_full", 32'(o_window_full), (t >= 15) ? 32'd1 : 32'd0);
        end
        chk("run_state", 32'(o_state), 32'(ST_RUN));

        // acc=5, then all lines spike together with the tick -> slot 13 replaces a 3
        step(8'h1F, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b0);
        chk("slot13_sum", o_spike_cnt, 32'd58);

        // Clear coincident with a tick: clear wins, no drop flag
        step('0, 1'b1, 1'b1);
        chk("clear_cnt_zero", o_spike_cnt, 32'd0);
        chk("clear_full_zero", 32'(o_window_full), 32'd0);
        chk("clear_tick_no_drop", 32'(o_tick_drop), 32'd0);
        for (int i = 0; i < WIN; i++) step('0, (i == 3), 1'b0);
        chk("init_tick_dropped", 32'(o_tick_drop), 32'd1);
        chk("refill_state", 32'(o_state), 32'(ST_FILL));

        // Reset mid-FILL with acc=7; INIT must again take the full WIN cycles
        step(8'h7F, 1'b0, 1'b0);
        do_reset();
        chk("reset_clears_drop", 32'(o_tick_drop), 32'd0);
        for (int i = 0; i < WIN - 1; i++) step('0, 1'b0, 1'b0);
        chk("still_init", 32'(o_state), 32'(ST_INIT));
        step('0, 1'b1, 1'b0);
        chk("last_init_tick_valid", 32'(o_cnt_valid), 32'd0);
        chk("last_init_tick_drop", 32'(o_tick_drop), 32'd1);
        step('0, 1'b1, 1'b0);
        chk("post_reset_tick_valid", 32'(o_cnt_valid), 32'd1);
        chk("post_reset_tick_cnt", o_spike_cnt, 32'd0);

        // Narrow-accumulator instance: 20 spikes in one tick clamp to 15
        chk("dut4_fill", 32'(o4_state), 32'(ST_FILL));
        chk("dut4_sat_before", 32'(o4_sat), 32'd0);
        spikes4 = 8'hFF;
        step('0, 1'b0, 1'b0);
        spikes4 = 8'hFF;
        step('0, 1'b0, 1'b0);
        spikes4 = 8'h0F;
        tick4   = 1'b1;
        step('0, 1'b0, 1'b0);
        spikes4 = '0;
        tick4   = 1'b0;
        chk("dut4_sat_valid", 32'(o4_cnt_valid), 32'd1);
        chk("dut4_sat_cnt", o4_spike_cnt, 32'd15);
        chk("dut4_sat_flag", 32'(o4_sat), 32'd1);
        spikes4 = 8'h01;
        tick4   = 1'b1;
        step('0, 1'b0, 1'b0);
        spikes4 = '0;
        tick4   = 1'b0;
        chk("dut4_next_cnt", o4_spike_cnt, 32'd16);
        chk("dut4_sat_sticky", 32'(o4_sat), 32'd1);
        step('0, 1'b0, 1'b0);
        chk("dut4_sat_sticky_idle", 32'(o4_sat), 32'd1);
        chk("dut4_no_drop", 32'(o4_tick_drop), 32'd0);
        chk("dut4_not_full", 32'(o4_window_full), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
